// File: rtl/cpu_pkg.sv
// Shared definitions for the 3-stage CPU: datapath width, register address width
// and the writeback source encodings.
package cpu_pkg;
    localparam int CPU_WIDTH  = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [1:0] REGSEL_ALU = 2'd0;
    localparam logic [1:0] REGSEL_HI  = 2'd1;
    localparam logic [1:0] REGSEL_LO  = 2'd2;
endpackage

// File: rtl/writeback_stage_if.sv
// EX-to-WB bundle: EX-stage control/data inputs, GPIO pins and the register-file write port.
interface writeback_stage_if #(
    parameter int WIDTH = cpu_pkg::CPU_WIDTH
);
    import cpu_pkg::*;

    logic                  stall_EX;
    logic [WIDTH-1:0]      lo_EX;
    logic [WIDTH-1:0]      hi_EX;
    logic [WIDTH-1:0]      rt_data_EX;
    logic [1:0]            regsel_EX;
    logic                  regwrite_EX;
    logic                  enhilo_EX;
    logic                  rdrt_EX;
    logic [REG_ADDR_W-1:0] rd_EX;
    logic [REG_ADDR_W-1:0] rt_EX;
    logic                  gpio_out_en_EX;
    logic                  gpio_in_en_EX;
    logic [WIDTH-1:0]      gpio_in;
    logic [WIDTH-1:0]      gpio_out;
    logic                  regwrite_WB;
    logic [REG_ADDR_W-1:0] writeaddr_WB;
    logic [WIDTH-1:0]      writedata_WB;
    logic [WIDTH-1:0]      hi_q;
    logic [WIDTH-1:0]      lo_q;

    modport master (
        output stall_EX, lo_EX, hi_EX, rt_data_EX, regsel_EX, regwrite_EX, enhilo_EX,
               rdrt_EX, rd_EX, rt_EX, gpio_out_en_EX, gpio_in_en_EX, gpio_in,
        input  gpio_out, regwrite_WB, writeaddr_WB, writedata_WB, hi_q, lo_q
    );

    modport slave (
        input  stall_EX, lo_EX, hi_EX, rt_data_EX, regsel_EX, regwrite_EX, enhilo_EX,
               rdrt_EX, rd_EX, rt_EX, gpio_out_en_EX, gpio_in_en_EX, gpio_in,
        output gpio_out, regwrite_WB, writeaddr_WB, writedata_WB, hi_q, lo_q
    );
endinterface

// File: rtl/writeback_stage_gpio_sync.sv
// Multi-flop synchronizer bringing the asynchronous GPIO input into the clk domain.
module gpio_sync #(
    parameter int WIDTH       = cpu_pkg::CPU_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] stage_q [SYNC_STAGES];

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
            logic [WIDTH-1:0] stage_d;
            if (gi == 0) begin : g_first
                assign stage_d = d_i;
            end else begin : g_rest
                assign stage_d = stage_q[gi-1];
            end

            always_ff @(posedge clk) begin
                if (rst) stage_q[gi] <= '0;
                else     stage_q[gi] <= stage_d;
            end
        end
    endgenerate

    assign q_o = stage_q[SYNC_STAGES-1];
endmodule

// File: rtl/writeback_stage.sv
// EX->WB pipeline register: owns HI/LO, GPIO out and the synchronized GPIO input,
// and drives the register-file write port (also the EX forwarding source).
module writeback_stage
    import cpu_pkg::*;
#(
    parameter int WIDTH       = CPU_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    writeback_stage_if.slave  bus
);
    logic                  v;
    logic [REG_ADDR_W-1:0] dest;
    logic [WIDTH-1:0]      gpio_sync;

    logic [WIDTH-1:0]      hi_q, hi_d;
    logic [WIDTH-1:0]      lo_q, lo_d;
    logic [WIDTH-1:0]      gpio_out_q, gpio_out_d;
    logic                  wb_en_q, wb_en_d;
    logic [REG_ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic [WIDTH-1:0]      wb_data_q, wb_data_d;

    gpio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_gpio_sync (
        .clk (clk),
        .rst (rst),
        .d_i (bus.gpio_in),
        .q_o (gpio_sync)
    );

    assign v    = ~bus.stall_EX;
    assign dest = bus.rdrt_EX ? bus.rt_EX : bus.rd_EX;

    // A bubble forces every enable low, so X on the EX fields never reaches state.
    always_comb begin
        hi_d       = hi_q;
        lo_d       = lo_q;
        gpio_out_d = gpio_out_q;
        if (v && bus.enhilo_EX) begin
            hi_d = bus.hi_EX;
            lo_d = bus.lo_EX;
        end
        if (v && bus.gpio_out_en_EX) begin
            gpio_out_d = bus.rt_data_EX;
        end
    end

    // mfhi/mflo read the pre-edge HI/LO, so a mult one cycle earlier is already visible.
    always_comb begin
        wb_en_d   = v && bus.regwrite_EX && (dest != '0);
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        if (wb_en_d) begin
            wb_addr_d = dest;
            if (bus.gpio_in_en_EX) begin
                wb_data_d = gpio_sync;
            end else begin
                case (bus.regsel_EX)
                    REGSEL_HI: wb_data_d = hi_q;
                    REGSEL_LO: wb_data_d = lo_q;
                    default:   wb_data_d = bus.lo_EX;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q       <= '0;
            lo_q       <= '0;
            gpio_out_q <= '0;
            wb_en_q    <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            gpio_out_q <= gpio_out_d;
            wb_en_q    <= wb_en_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign bus.hi_q         = hi_q;
    assign bus.lo_q         = lo_q;
    assign bus.gpio_out     = gpio_out_q;
    assign bus.regwrite_WB  = wb_en_q;
    assign bus.writeaddr_WB = wb_addr_q;
    assign bus.writedata_WB = wb_data_q;
endmodule

// File: doc/writeback_stage.md
# writeback_stage

EX→WB pipeline register and writeback stage of the 3-stage CPU. It sits directly downstream of the control unit and ALU. It captures the EX-stage control signals and the ALU result, and owns the HI/LO registers, the GPIO output register and the GPIO input synchronizer. It drives the register-file write port, whose outputs also serve as the forwarding source for EX.

## Interface
Parameters:
- WIDTH, 32, datapath width
- SYNC_STAGES, 2, GPIO input synchronizer depth (≥2)

Ports:
- clk  in  1  system clock; one clock domain, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- stall_EX  in  1  1 = EX holds a bubble; all EX inputs are don't-care (may be X)
- lo_EX  in  WIDTH  ALU low result (also the normal ALU result)
- hi_EX  in  WIDTH  ALU high result (mult/multu only)
- rt_data_EX  in  WIDTH  register read data of rt; source for GPIO writes
- regsel_EX  in  2  0 ALU, 1 mfhi, 2 mflo, 3 reserved
- regwrite_EX  in  1  instruction writes a register
- enhilo_EX  in  1  instruction writes HI/LO
- rdrt_EX  in  1  destination select: 1 rt, 0 rd
- rd_EX, rt_EX  in  5  register addresses (instr[15:11], instr[20:16])
- gpio_out_en_EX  in  1  srl with shamt 0: write GPIO out
- gpio_in_en_EX  in  1  sra with shamt 0: read GPIO in
- gpio_in  in  WIDTH  asynchronous external input (switches)
- gpio_out  out  WIDTH  registered GPIO output (displays)
- regwrite_WB  out  1  register-file write enable
- writeaddr_WB  out  5  register-file write address
- writedata_WB  out  WIDTH  register-file write data
- hi_q, lo_q  out  WIDTH  current HI/LO register contents

## Operation
- Qualification: `v = ~stall_EX`. Every side effect is gated by v, so X on EX inputs during a bubble must never propagate into state.
- HI/LO: on an edge where `v & enhilo_EX`, HI ← hi_EX and LO ← lo_EX. Otherwise they hold.
- GPIO out: on an edge where `v & gpio_out_en_EX`, gpio_out ← rt_data_EX. Otherwise it holds.
- GPIO in: gpio_in passes through a SYNC_STAGES-deep flop chain to produce gpio_sync.
- WB data capture on each edge:
  - If `v & gpio_in_en_EX`: gpio_sync.
  - Else if regsel_EX=1: the current HI register, i.e. the pre-edge value.
  - Else if regsel_EX=2: the current LO register.
  - Otherwise (0 or 3): lo_EX.
- WB address capture: rt_EX if rdrt_EX=1, else rd_EX.
- WB enable capture: `v & regwrite_EX & (dest≠0)`. Writes to $0 are suppressed here.
- When the enable captures 0, the captured data and address are don't-care but must not be X. Hold the previous values.
- regwrite_WB, writeaddr_WB and writedata_WB are driven directly from the WB registers, with no combinational path from EX inputs.

## Timing
- Reset, on a synchronous edge with rst=1: HI, LO, gpio_out, all synchronizer flops, regwrite_WB, writeaddr_WB and writedata_WB all go to 0. Reset overrides every concurrent enable. Reset asserted mid-sequence discards the in-flight instruction.
- Latency: an instruction in EX during cycle n appears on the WB outputs during cycle n+1. The register file writes at the end of cycle n+1.
- HI/LO latency: after a mult in EX at cycle n, HI/LO update at the end of n. An mfhi/mflo in EX at cycle n+1 captures the new value, with no hazard bubble.
- Simultaneous enhilo_EX with regsel_EX=1/2 in the same instruction: the captured data uses the pre-update HI/LO.
- gpio_out_en_EX and gpio_in_en_EX both set: both actions occur. The WB data is gpio_sync.
- GPIO input latency: a change on gpio_in is visible in gpio_sync after SYNC_STAGES edges. A read in EX at cycle n captures gpio_sync as of the end of n−1.
- A bubble (stall_EX=1) forces regwrite_WB=0 the next cycle. HI/LO and gpio_out hold.

## Structure
- Shared package cpu_pkg holds:
  - REGSEL_ALU=2'd0, REGSEL_HI=2'd1, REGSEL_LO=2'd2
  - the register address width (5)
  - the WIDTH default
- One sub-module, gpio_sync: a parameterised SYNC_STAGES flop chain with synchronous reset.
- HI/LO, the GPIO out register and the WB registers stay in the top module.

## Test plan
- Reset: hold rst 2 cycles with all enables high and lo_EX=32'hFFFF_FFFF → every output reads 0. Release rst → outputs stay 0 until the first valid instruction.
- Add path: regwrite_EX=1, rdrt_EX=0, rd_EX=5, lo_EX=32'h0000_0007 → next cycle regwrite_WB=1, writeaddr_WB=5, writedata_WB=7.
- Mult then mfhi/mflo:
  - Cycle n: enhilo_EX=1, hi_EX=32'h1, lo_EX=32'h8000_0000.
  - Cycle n+1: regsel_EX=1, rd_EX=3, which gives writedata_WB=1 at n+2.
  - Cycle n+2: regsel_EX=2, which gives writedata_WB=32'h8000_0000 at n+3.
- GPIO: gpio_in=32'hA5 held for 3 cycles, then gpio_in_en_EX=1, rd_EX=9 → writedata_WB=32'hA5. Then gpio_out_en_EX=1, rt_data_EX=32'h3C → gpio_out=32'h3C one edge later, holding thereafter.
- Bubble and $0: stall_EX=1 with all EX inputs X → regwrite_WB=0 and HI/LO/gpio_out unchanged. Then regwrite_EX=1, rdrt_EX=1, rt_EX=0 → regwrite_WB=0.
- Reset mid-operation: a mult in EX with rst=1 on the same edge → HI=LO=0, and the following mfhi writes 0.
